// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : uart_tx_fifo_pkg                                                 |
// | Shared UART data width, transmit FSM state encoding and FIFO helpers.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } tx_state_t;

  // A byte is accepted when there is room, or when a pop frees a slot this cycle.
  function automatic logic can_accept(input logic full, input logic pop);
    return !full || pop;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_fifo_mem                                                     |
// | Circular byte store with wrapping pointers, occupancy count, full/empty.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module uart_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = UART_DATA_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_tx_fifo                                                      |
// | Elastic byte buffer from UART receiver to transmitter, paced by tx_busy.   |
// | Optional macro UART_TX_FIFO_FLUSH_EN: rx_break flushes stored bytes.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = UART_DATA_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_break,
  input  logic             tx_busy,
  output logic             tx_en,
  output logic [WIDTH-1:0] tx_data,
  output logic [CW-1:0]    fifo_count,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow,
  input  logic             overflow_clr
);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_flush;
  logic             w_drop;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_overflow;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign w_flush = rx_break;
`else
  logic unused_rx_break;
  assign unused_rx_break = rx_break;
  assign w_flush         = 1'b0;
`endif

  assign w_pop  = (r_state == LAUNCH);
  assign w_push = rx_valid && can_accept(fifo_full, w_pop) && !w_flush;
  assign w_drop = rx_valid && !can_accept(fifo_full, w_pop);

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (w_flush),
    .wr_data   (rx_data),
    .head_data (w_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A flush on the launch-decision cycle would leave LAUNCH popping an empty store.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!fifo_empty && !tx_busy && !w_flush) w_state_nxt = LAUNCH;
      LAUNCH:  w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = DRAIN;
      DRAIN:   if (!tx_busy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The head byte is captured on entry to LAUNCH so tx_data is valid alongside tx_en.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_data <= '0;
    end else if (r_state == IDLE && w_state_nxt == LAUNCH) begin
      r_tx_data <= w_head;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign tx_en    = (r_state == LAUNCH);
  assign tx_data  = r_tx_data;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_tx_fifo                                                   |
// | Scoreboard bench for uart_tx_fifo with a behavioural transmitter.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             rx_valid = 1'b0;
  logic [WIDTH-1:0] rx_data = '0;
  logic             rx_break = 1'b0;
  logic             overflow_clr = 1'b0;
  logic             hold = 1'b0;
  logic             model_busy = 1'b0;
  logic             tx_busy;
  logic             tx_en;
  logic [WIDTH-1:0] tx_data;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             overflow;

  int busy_cnt = 0;
  int tx_len   = 10;
  int checks   = 0;
  int errors   = 0;
  logic [WIDTH-1:0] exp_q [$];

  assign tx_busy = model_busy | hold;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_break     (rx_break),
    .tx_busy      (tx_busy),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .fifo_count   (fifo_count),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transmitter: busy from the launch cycle for tx_len cycles; launched bytes scored in order.
  always @(negedge clk) begin
    if (!resetn) begin
      model_busy = 1'b0;
      busy_cnt   = 0;
    end else begin
      if (tx_en) begin
        check("tx_en_while_busy", tx_busy, 0);
        check("tx_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_data_order", tx_data, exp_q.pop_front());
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) model_busy = 1'b0;
      end
      if (tx_en) begin
        model_busy = 1'b1;
        busy_cnt   = tx_len;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] b, input bit accept);
    rx_valid = 1'b1;
    rx_data  = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(fifo_empty && !tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_timeout"}, n < budget, 1);
    repeat (3) @(negedge clk);
    check({tag, "_all_sent"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int seen;

    repeat (3) @(negedge clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single byte latency and pulse width
    send(8'hA5, 1'b1);
    check("t2_count_after_write", fifo_count, 1);
    check("t2_no_early_tx_en", tx_en, 0);
    @(negedge clk);
    check("t2_tx_en_latency", tx_en, 1);
    check("t2_tx_data", tx_data, 8'hA5);
    @(negedge clk);
    check("t2_tx_en_one_cycle", tx_en, 0);
    check("t2_count_after_pop", fifo_count, 0);
    wait_drain("t2", 40);

    // Reset while draining with bytes stored
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    check("t1_stored_before_reset", fifo_count, 3);
    check("t1_busy_before_reset", tx_busy, 1);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t1_rst_tx_en", tx_en, 0);
    check("t1_rst_tx_data", tx_data, 0);
    check("t1_rst_count", fifo_count, 0);
    check("t1_rst_empty", fifo_empty, 1);
    check("t1_rst_overflow", overflow, 0);
    resetn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(tx_en);
    end
    check("t1_no_tx_after_reset", seen, 0);

    // Fill, overflow, clear, then write coinciding with a pop
    hold = 1'b1;
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b1);
    check("t3_full", fifo_full, 1);
    check("t3_count16", fifo_count, 16);
    send(8'hFF, 1'b0);
    check("t4_overflow_set", overflow, 1);
    check("t4_count_held", fifo_count, 16);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("t4_overflow_cleared", overflow, 0);
    hold = 1'b0;
    n = 0;
    while (!tx_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_launch_timeout", n < 20, 1);
    check("t5_count_at_launch", fifo_count, 16);
    send(8'h11, 1'b1);
    check("t5_count_stays16", fifo_count, 16);
    check("t5_no_overflow", overflow, 0);
    check("t5_still_full", fifo_full, 1);
    wait_drain("t3", 600);
    check("t3_empty_end", fifo_empty, 1);

    // Stream 40 bytes to wrap the pointers
    tx_len = 3;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (fifo_full && n < 200) begin
        @(negedge clk);
        n++;
      end
      send(8'h40 + 8'(i), 1'b1);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_drain("wrap", 800);
    check("wrap_no_overflow", overflow, 0);

    // Break with 5 bytes stored behind an in-flight byte
    tx_len = 10;
    for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    check("t6_stored", fifo_count, 5);
    rx_break = 1'b1;
`ifdef UART_TX_FIFO_FLUSH_EN
    send(8'h77, 1'b0);
    rx_break = 1'b0;
    exp_q.delete();
    check("t6_flushed_count", fifo_count, 0);
`else
    send(8'h77, 1'b1);
    rx_break = 1'b0;
    check("t6_break_ignored_count", fifo_count, 6);
`endif
    wait_drain("t6", 300);
    check("t6_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
